// File: rtl/ptfifo.sv
// ptfifo: show-ahead valid/ready FIFO buffering plaintext candidates for the MD5 core
module ptfifo #(
  parameter int WIDTH     = 128,
  parameter int ADDR_W    = 2,
  parameter int AFULL_LVL = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              almost_full
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push, pop;
  // Status and handshakes come from registered count only; head word is masked when empty
  always_comb begin
    in_ready    = count != (ADDR_W+1)'(DEPTH);
    out_valid   = count != '0;
    almost_full = count >= (ADDR_W+1)'(AFULL_LVL);
    out_data    = out_valid ? mem[rd_ptr] : '0;
    push        = in_valid & in_ready;
    pop         = out_valid & out_ready;
  end
  // Pointer and occupancy bookkeeping; flush discards any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end
  end
  // Storage is deliberately left unreset; only accepted pushes write it
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end
endmodule

// File: tb/tb_ptfifo.sv
// tb_ptfifo: randomized and directed check of ptfifo against a queue-based model
module tb_ptfifo;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         flush = 0;
  logic [127:0] in_data = '0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready = 0;
  logic [2:0]   count;
  logic         almost_full;
  int vectors = 0;
  int miscompares = 0;
  bit armed = 0;
  logic [127:0] q[$];

  ptfifo #(.WIDTH(128), .ADDR_W(2), .AFULL_LVL(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of at most 4 words, cleared by reset or flush
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else if (flush) q.delete();
    else begin
      bit p, o;
      p = in_valid && q.size() < 4;
      o = out_ready && q.size() > 0;
      if (o) void'(q.pop_front());
      if (p) q.push_back(in_data);
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (armed) begin
      int n;
      n = q.size();
      chk("count", 128'(count), 128'(n));
      chk("out_valid", 128'(out_valid), 128'(n != 0));
      chk("in_ready", 128'(in_ready), 128'(n != 4));
      chk("almost_full", 128'(almost_full), 128'(n >= 3));
      chk("out_data", out_data, n != 0 ? q[0] : 128'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(logic [127:0] d);
    in_data = d;
    in_valid = 1;
    step();
    in_valid = 0;
  endtask

  initial begin
    step();
    armed = 1;
    step();
    rst_n = 1;
    chk("rst count", 128'(count), 0);
    chk("rst out_valid", 128'(out_valid), 0);
    chk("rst in_ready", 128'(in_ready), 1);
    chk("rst out_data", out_data, 0);
    chk("rst almost_full", 128'(almost_full), 0);
    push_word(128'h0123456789ABCDEF0123456789ABCDEF);
    chk("t2 out_valid", 128'(out_valid), 1);
    chk("t2 out_data", out_data, 128'h0123456789ABCDEF0123456789ABCDEF);
    chk("t2 count", 128'(count), 1);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t2 drained", 128'(out_valid), 0);
    for (int i = 1; i <= 4; i++) begin
      push_word(128'(i));
      if (i == 2) chk("t3 af at 2", 128'(almost_full), 0);
      if (i == 3) chk("t3 af at 3", 128'(almost_full), 1);
    end
    chk("t3 full in_ready", 128'(in_ready), 0);
    chk("t3 full count", 128'(count), 4);
    push_word(128'd5);
    chk("t3 dropped count", 128'(count), 4);
    chk("t3 head", out_data, 1);
    in_data = 128'd5;
    in_valid = 1;
    out_ready = 1;
    step();
    chk("t4 pop only count", 128'(count), 3);
    chk("t4 head 2", out_data, 2);
    chk("t4 in_ready back", 128'(in_ready), 1);
    step();
    chk("t4 push+pop count", 128'(count), 3);
    chk("t4 head 3", out_data, 3);
    in_valid = 0;
    step();
    chk("t4 head 4", out_data, 4);
    step();
    chk("t4 head 5", out_data, 5);
    step();
    chk("t4 empty", 128'(out_valid), 0);
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      in_data = 128'(100 + i);
      step();
      chk("t5 stream count", 128'(count), 1);
      chk("t5 stream head", out_data, 128'(100 + i));
    end
    in_valid = 0;
    step();
    out_ready = 0;
    push_word(128'hA1);
    push_word(128'hA2);
    push_word(128'hA3);
    chk("t6 count 3", 128'(count), 3);
    flush = 1;
    in_data = 128'hDEAD;
    in_valid = 1;
    out_ready = 1;
    step();
    flush = 0;
    in_valid = 0;
    out_ready = 0;
    chk("t6 flush count", 128'(count), 0);
    chk("t6 flush out_valid", 128'(out_valid), 0);
    push_word(128'hAA);
    chk("t6 after flush head", out_data, 128'hAA);
    push_word(128'hBB);
    chk("t6 refill count", 128'(count), 2);
    #2;
    rst_n = 0;
    #1;
    chk("t6 async out_valid", 128'(out_valid), 0);
    chk("t6 async count", 128'(count), 0);
    chk("t6 async out_data", out_data, 0);
    step();
    rst_n = 1;
    push_word(128'h77);
    chk("t6 first push count", 128'(count), 1);
    chk("t6 first push head", out_data, 128'h77);
    for (int i = 0; i < 3000; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) == 0 ? 1'b1 : (i[9] ? 1'b1 : 1'b0);
      flush = $urandom_range(0, 63) == 0;
      step();
    end
    flush = 0;
    in_valid = 0;
    out_ready = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ptfifo.md
Name: ptfifo

Overview:
Parametrised plaintext-candidate buffer that sits between the candidate generator and the MD5 core. It replaces the single edge-latched plaintext register with a clocked, reset-able FIFO of WIDTH-bit words. Both sides use valid/ready handshakes, and the block adds occupancy, almost-full and flush features. This lets the generator run ahead of the core by up to DEPTH candidates without losing or duplicating words.

Parameters:
WIDTH, 128, bits per plaintext word (min 1)
ADDR_W, 2, pointer width; DEPTH = 2**ADDR_W entries (ADDR_W >= 1)
AFULL_LVL, 3, almost_full asserts when count >= AFULL_LVL (1..DEPTH)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all buffered words
in_data  input  WIDTH  plaintext word from generator
in_valid  input  1  in_data valid
in_ready  output  1  FIFO can accept a word this cycle
out_data  output  WIDTH  head word to MD5 core
out_valid  output  1  out_data valid (FIFO not empty)
out_ready  input  1  core consumes head word this cycle
count  output  ADDR_W+1  words currently held (0..DEPTH)
almost_full  output  1  count >= AFULL_LVL

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Outputs: out_valid=0, in_ready=1, almost_full=0, out_data=0. Storage array is not reset.
- push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the rising edge.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready.
- out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, all-zero otherwise (masked).
- Show-ahead: the head word is on out_data whenever out_valid=1. Write-to-read latency is 1 cycle: a word pushed at edge N is visible and out_valid=1 after edge N.
- push only: mem[wr_ptr]<=in_data, wr_ptr+1, count+1.
- pop only: rd_ptr+1, count-1.
- push & pop same edge: write and read both happen, pointers both advance, count unchanged.
- Full (count=DEPTH): in_ready=0, so the push is dropped by the handshake. A same-cycle pop still proceeds, and in_ready returns to 1 the next cycle.
- Empty (count=0): out_valid=0, so no pop occurs. A same-cycle push lands normally, and out_valid=1 the next cycle.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- flush=1 at an edge sets pointers=0 and count=0. It takes priority over any push or pop in the same cycle; both are discarded.
- rst_n asserted mid-operation: all held words are lost immediately and outputs take their reset values without waiting for a clock. Deassertion is synchronised upstream, and the first push is accepted at the first edge after release.
- almost_full is derived combinationally from the registered count.
- Word ordering is strictly FIFO. Data is never modified: bit-exact WIDTH-bit transfer.

Test Plan:
1. Reset then idle: count=0, out_valid=0, in_ready=1, out_data=0, almost_full=0.
2. Push 0x0123..CDEF (128b) with out_ready=0 -> next cycle out_valid=1, out_data=0x0123..CDEF, count=1.
3. Fill: push words 1,2,3,4 with out_ready=0. Expect almost_full=1 at count=3 and in_ready=0 at count=4. A 5th push with in_valid=1 is not accepted and count stays 4. Then pop 4 -> outputs 1,2,3,4 in order, and out_valid=0 after the last.
4. Full with simultaneous push & pop: at count=4, push 5 with out_ready=1. in_ready=0, so only the pop occurs: out 1, count=3. Next cycle push 5 and pop together -> count stays 3, output order 2,3,4,5.
5. Streaming: in_valid=out_ready=1 for 20 cycles with an incrementing pattern. Expect throughput 1 word/cycle after 1-cycle latency, count=1 steady, no drops or duplicates.
6. Flush and reset: with count=3, assert flush together with a push and a pop -> next cycle count=0, out_valid=0, and the pushed word is absent. Refill to 2, then pulse rst_n low mid-cycle -> out_valid=0 and count=0 immediately, before any clock edge.
